// File: rtl/riscv_defines.sv
// Shared definitions for the EX-to-MEM result queue: entry layout and
// functional-unit source indices.
package riscv_defines;

    localparam int unsigned EXQ_DATA_W = 32;
    localparam int unsigned EXQ_ADDR_W = 6;

    // Result source indices into src_sel_i / src_data_i / src_ready_i
    localparam int unsigned EXQ_SRC_ALU = 0;
    localparam int unsigned EXQ_SRC_DIV = 1;
    localparam int unsigned EXQ_SRC_MUL = 2;
    localparam int unsigned EXQ_SRC_CSR = 3;

    typedef struct packed {
        logic                  we;
        logic [EXQ_ADDR_W-1:0] waddr;
        logic [EXQ_DATA_W-1:0] wdata;
    } ex_wb_entry_t;

endpackage

// File: rtl/riscv_onehot_mux.sv
// Result source selector: lowest set bit of sel wins; no bit set yields
// zero data with ready forced high. err flags a select that is not one-hot.
module riscv_onehot_mux #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DATA_W  = 32
) (
    input  logic [NUM_SRC-1:0]        sel,
    input  logic [NUM_SRC*DATA_W-1:0] data,
    input  logic [NUM_SRC-1:0]        ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_ready,
    output logic                      err
);

    // Priority pick of the lowest selected source plus population count
    always_comb begin
        logic        found;
        int unsigned ones;
        out_data  = '0;
        out_ready = 1'b1;
        found     = 1'b0;
        ones      = 0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (sel[k]) begin
                ones = ones + 1;
                if (!found) begin
                    found     = 1'b1;
                    out_data  = data[k*DATA_W +: DATA_W];
                    out_ready = ready[k];
                end
            end
        end
        err = (ones != 1);
    end

endmodule

// File: rtl/riscv_ex_wb_queue.sv
// EX-to-MEM result FIFO fed by several functional units, with a
// youngest-first forwarding lookup over the incoming push and queued entries.
module riscv_ex_wb_queue
    import riscv_defines::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DEPTH   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    input  logic [NUM_SRC-1:0]        src_sel_i,
    input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
    input  logic [NUM_SRC-1:0]        src_ready_i,
    input  logic                      we_i,
    input  logic [ADDR_W-1:0]         waddr_i,
    output logic                      in_ready_o,
    output logic                      sel_err_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      out_we_o,
    output logic [ADDR_W-1:0]         out_waddr_o,
    output logic [DATA_W-1:0]         out_wdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    input  logic [ADDR_W-1:0]         fw_raddr_i,
    output logic                      fw_hit_o,
    output logic [DATA_W-1:0]         fw_data_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic [DATA_W-1:0] sel_data;
    logic              sel_ready;
    logic              sel_err;
    logic              push;
    logic              pop;

    riscv_onehot_mux #(
        .NUM_SRC (NUM_SRC),
        .DATA_W  (DATA_W)
    ) u_src_mux (
        .sel       (src_sel_i),
        .data      (src_data_i),
        .ready     (src_ready_i),
        .out_data  (sel_data),
        .out_ready (sel_ready),
        .err       (sel_err)
    );

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign out_valid_o = (count != '0);
    assign sel_err_o   = in_valid_i & sel_err;
    assign push        = in_valid_i & sel_ready & ~flush_i &
                         ((count < CW'(DEPTH)) | (out_valid_o & out_ready_i));
    assign pop         = out_valid_o & out_ready_i & ~flush_i;
    assign in_ready_o  = push;
    assign count_o     = count;

    assign out_we_o    = out_valid_o ? mem[rd_ptr].we    : 1'b0;
    assign out_waddr_o = out_valid_o ? mem[rd_ptr].waddr : '0;
    assign out_wdata_o = out_valid_o ? mem[rd_ptr].wdata : '0;

    // Pointer and occupancy bookkeeping; flush returns to the empty state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Entry storage; contents are only observed while counted as occupied
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{we: we_i, waddr: waddr_i, wdata: sel_data};
    end

    // Forwarding candidates, slot i is the (i+1)-th youngest queued entry
    logic [DEPTH-1:0]  q_hit;
    logic [DATA_W-1:0] q_data [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_fw
        localparam int unsigned OFF = i + 1;
        logic [PW-1:0] idx;

        // Walk backwards from the write pointer, wrapping below slot 0
        always_comb begin
            if (int'(wr_ptr) >= int'(OFF)) idx = PW'(int'(wr_ptr) - int'(OFF));
            else                           idx = PW'(int'(wr_ptr) + int'(DEPTH) - int'(OFF));
        end

        assign q_hit[i]  = (CW'(i) < count) && mem[idx].we && (mem[idx].waddr == fw_raddr_i);
        assign q_data[i] = mem[idx].wdata;
    end

    logic in_hit;
    assign in_hit = in_valid_i & sel_ready & we_i & (waddr_i == fw_raddr_i);

    // Priority resolve: incoming push, then queued entries youngest first
    always_comb begin
        logic found;
        found     = 1'b0;
        fw_hit_o  = 1'b0;
        fw_data_o = '0;
        if (!flush_i && (fw_raddr_i != '0)) begin
            if (in_hit) begin
                found     = 1'b1;
                fw_hit_o  = 1'b1;
                fw_data_o = sel_data;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (q_hit[i] && !found) begin
                    found     = 1'b1;
                    fw_hit_o  = 1'b1;
                    fw_data_o = q_data[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_ex_wb_queue.sv
// Directed bench for riscv_ex_wb_queue with default parameters (DEPTH=2).
module tb_riscv_ex_wb_queue;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 6;
    localparam int unsigned NS = 4;
    localparam int unsigned DP = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush_i;
    logic            in_valid_i;
    logic [NS-1:0]   src_sel_i;
    logic [NS*DW-1:0] src_data_i;
    logic [NS-1:0]   src_ready_i;
    logic            we_i;
    logic [AW-1:0]   waddr_i;
    logic            in_ready_o;
    logic            sel_err_o;
    logic            out_valid_o;
    logic            out_ready_i;
    logic            out_we_o;
    logic [AW-1:0]   out_waddr_o;
    logic [DW-1:0]   out_wdata_o;
    logic [$clog2(DP+1)-1:0] count_o;
    logic [AW-1:0]   fw_raddr_i;
    logic            fw_hit_o;
    logic [DW-1:0]   fw_data_o;

    int n_checks = 0;
    int n_pass   = 0;

    riscv_ex_wb_queue #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .NUM_SRC (NS),
        .DEPTH   (DP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .src_sel_i   (src_sel_i),
        .src_data_i  (src_data_i),
        .src_ready_i (src_ready_i),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .in_ready_o  (in_ready_o),
        .sel_err_o   (sel_err_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_we_o    (out_we_o),
        .out_waddr_o (out_waddr_o),
        .out_wdata_o (out_wdata_o),
        .count_o     (count_o),
        .fw_raddr_i  (fw_raddr_i),
        .fw_hit_o    (fw_hit_o),
        .fw_data_o   (fw_data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a push from source index k with the given select mask
    task automatic offer(input logic [NS-1:0] sel, input int k, input logic [31:0] d,
                         input logic [AW-1:0] wa);
        in_valid_i = 1'b1;
        src_sel_i  = sel;
        src_data_i = '0;
        src_data_i[k*DW +: DW] = d;
        we_i       = 1'b1;
        waddr_i    = wa;
    endtask

    initial begin
        rst_n       = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        src_sel_i   = '0;
        src_data_i  = '0;
        src_ready_i = '1;
        we_i        = 1'b0;
        waddr_i     = '0;
        out_ready_i = 1'b0;
        fw_raddr_i  = '0;

        // Reset state
        #12;
        check("rst_count", 32'(count_o), 0);
        check("rst_valid", 32'(out_valid_o), 0);
        check("rst_wdata", out_wdata_o, 0);
        check("rst_in_ready", 32'(in_ready_o), 0);
        check("rst_fw_hit", 32'(fw_hit_o), 0);
        rst_n = 1'b1;
        step();

        // Single ALU push, held at the head
        offer(4'b0001, 0, 32'h0000_1234, 6'd5);
        #1;
        check("alu_in_ready", 32'(in_ready_o), 1);
        check("alu_sel_err", 32'(sel_err_o), 0);
        check("alu_no_bypass", 32'(out_valid_o), 0);
        step();
        in_valid_i = 1'b0;
        #1;
        check("alu_count", 32'(count_o), 1);
        check("alu_wdata", out_wdata_o, 32'h1234);
        check("alu_waddr", 32'(out_waddr_o), 5);
        check("alu_we", 32'(out_we_o), 1);
        step();
        check("alu_hold", out_wdata_o, 32'h1234);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        check("alu_drained", 32'(count_o), 0);
        check("alu_out_zero", out_wdata_o, 0);

        // Full queue with simultaneous pop and push
        offer(4'b0001, 0, 32'hA, 6'd1);
        step();
        offer(4'b0001, 0, 32'hB, 6'd2);
        step();
        offer(4'b0001, 0, 32'hC, 6'd3);
        #1;
        check("full_count", 32'(count_o), 2);
        check("full_in_ready", 32'(in_ready_o), 0);
        step();
        check("full_stall_count", 32'(count_o), 2);
        check("full_head_a", out_wdata_o, 32'hA);
        out_ready_i = 1'b1;
        #1;
        check("full_popush_rdy", 32'(in_ready_o), 1);
        step();
        in_valid_i = 1'b0;
        #1;
        check("popush_count", 32'(count_o), 2);
        check("order_b", out_wdata_o, 32'hB);
        step();
        check("order_c", out_wdata_o, 32'hC);
        check("order_c_count", 32'(count_o), 1);
        step();
        out_ready_i = 1'b0;
        check("order_empty", 32'(count_o), 0);

        // Forwarding priority
        offer(4'b0001, 0, 32'h11, 6'd7);
        step();
        offer(4'b0001, 0, 32'h22, 6'd7);
        step();
        offer(4'b0100, 2, 32'h33, 6'd7);
        fw_raddr_i = 6'd7;
        #1;
        check("fw_in_hit", 32'(fw_hit_o), 1);
        check("fw_in_data", fw_data_o, 32'h33);
        in_valid_i = 1'b0;
        #1;
        check("fw_young", fw_data_o, 32'h22);
        fw_raddr_i = 6'd0;
        #1;
        check("fw_r0_hit", 32'(fw_hit_o), 0);
        fw_raddr_i = 6'd3;
        #1;
        check("fw_miss_hit", 32'(fw_hit_o), 0);
        check("fw_miss_data", fw_data_o, 0);

        // Flush together with a push that would otherwise be accepted
        fw_raddr_i  = 6'd7;
        out_ready_i = 1'b1;
        offer(4'b0001, 0, 32'h44, 6'd9);
        flush_i = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready_o), 0);
        check("flush_fw_hit", 32'(fw_hit_o), 0);
        step();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        #1;
        check("flush_count", 32'(count_o), 0);
        check("flush_valid", 32'(out_valid_o), 0);
        step();
        check("flush_no_ghost", 32'(out_valid_o), 0);
        out_ready_i = 1'b0;

        // Divider not ready for three cycles
        offer(4'b0010, 1, 32'hD1D1, 6'd10);
        src_ready_i = 4'b1101;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("div_wait_rdy", 32'(in_ready_o), 0);
            step();
            check("div_wait_count", 32'(count_o), 0);
        end
        src_ready_i = 4'b1111;
        #1;
        check("div_go_rdy", 32'(in_ready_o), 1);
        step();
        in_valid_i = 1'b0;
        #1;
        check("div_data", out_wdata_o, 32'hD1D1);
        check("div_waddr", 32'(out_waddr_o), 10);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;

        // No source selected: zero data, treated as ready, error flagged
        offer(4'b0000, 0, 32'hFFFF, 6'd4);
        src_ready_i = 4'b0000;
        #1;
        check("nosel_err", 32'(sel_err_o), 1);
        check("nosel_rdy", 32'(in_ready_o), 1);
        step();
        in_valid_i  = 1'b0;
        src_ready_i = 4'b1111;
        #1;
        check("nosel_data", out_wdata_o, 0);
        check("nosel_waddr", 32'(out_waddr_o), 4);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;

        // Multi-hot select picks the lowest bit
        offer(4'b0110, 1, 32'h5151, 6'd12);
        src_data_i[2*DW +: DW] = 32'h6262;
        #1;
        check("multi_err", 32'(sel_err_o), 1);
        check("multi_rdy", 32'(in_ready_o), 1);
        step();
        offer(4'b1000, 3, 32'h7777, 6'd13);
        step();
        in_valid_i = 1'b0;
        #1;
        check("multi_data", out_wdata_o, 32'h5151);
        check("multi_count", 32'(count_o), 2);

        // Asynchronous reset mid-stream
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count_o), 0);
        check("arst_valid", 32'(out_valid_o), 0);
        check("arst_wdata", out_wdata_o, 0);
        check("arst_waddr", 32'(out_waddr_o), 0);
        check("arst_we", 32'(out_we_o), 0);
        #3;
        rst_n = 1'b1;
        offer(4'b0001, 0, 32'h9999, 6'd2);
        step();
        in_valid_i = 1'b0;
        #1;
        check("post_rst_count", 32'(count_o), 1);
        check("post_rst_data", out_wdata_o, 32'h9999);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
